// File: rtl/encrypt.sv
// Iterative single-DES encryptor: one load cycle then one Feistel round per clock.
// The ciphertext register is refreshed every 17 clocks from the message/key captured at load.
module encrypt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [64:1] message,
    input  logic [64:1] key,
    output logic [64:1] cipher
);

    // DES bit n of an N-bit vector lives at index N+1-n (DES bit 1 is the MSB).
    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

    localparam int FP_T [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Flattened S-boxes: entry = box*64 + row*16 + column.
    localparam int SBOX [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

    logic [4:0]  cnt;
    logic [32:1] l, r;
    logic [28:1] c, d;

    logic [64:1] ip_m, pre, fp_o;
    logic [56:1] pc1_k, cd;
    logic [28:1] c_rot, d_rot;
    logic [48:1] kk, e, x;
    logic [32:1] so, f, r_nxt;
    logic        one_shift;

    assign one_shift = (cnt == 5'd1) || (cnt == 5'd2) || (cnt == 5'd9) || (cnt == 5'd16);
    assign c_rot = one_shift ? {c[27:1], c[28]} : {c[26:1], c[28:27]};
    assign d_rot = one_shift ? {d[27:1], d[28]} : {d[26:1], d[28:27]};
    assign cd    = {c_rot, d_rot};
    assign x     = e ^ kk;
    assign r_nxt = l ^ f;
    // Preoutput is R16||L16: the final round's halves, swapped.
    assign pre   = {r_nxt, r};

    genvar j, s;
    generate
        for (j = 1; j <= 64; j++) begin : g_p64
            assign ip_m[65-j] = message[65-IP_T[j-1]];
            assign fp_o[65-j] = pre[65-FP_T[j-1]];
        end
        for (j = 1; j <= 56; j++) begin : g_pc1
            assign pc1_k[57-j] = key[65-PC1_T[j-1]];
        end
        for (j = 1; j <= 48; j++) begin : g_p48
            assign e[49-j]  = r[33-E_T[j-1]];
            assign kk[49-j] = cd[57-PC2_T[j-1]];
        end
        for (j = 1; j <= 32; j++) begin : g_p32
            assign f[33-j] = so[33-P_T[j-1]];
        end
        for (s = 0; s < 8; s++) begin : g_sbox
            logic [5:0] six;
            logic [8:0] sidx;
            logic [31:0] ent;
            assign six  = x[48-6*s -: 6];
            assign sidx = {3'(s), six[5], six[0], six[4:1]};
            assign ent  = 32'(SBOX[sidx]);
            assign so[32-4*s -: 4] = ent[3:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            l      <= '0;
            r      <= '0;
            c      <= '0;
            d      <= '0;
            cipher <= '0;
        end else if (cnt == 5'd0) begin
            {l, r} <= ip_m;
            {c, d} <= pc1_k;
            cnt    <= 5'd1;
        end else begin
            l <= r;
            r <= r_nxt;
            c <= c_rot;
            d <= d_rot;
            if (cnt == 5'd16) begin
                cipher <= fp_o;
                cnt    <= 5'd0;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_encrypt.sv
// Directed bench for the iterative DES encryptor using known FIPS vectors.
module tb_encrypt;

    logic        clk;
    logic        rst_n;
    logic [64:1] message;
    logic [64:1] key;
    logic [64:1] cipher;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] K_STD   = 64'h0123456789ABCDEF;
    localparam logic [63:0] K_PAR   = 64'h0022446688AACCEE;
    localparam logic [63:0] K_ALT   = 64'h133457799BBCDFF1;
    localparam logic [63:0] M_STD   = 64'h0123456789ABCDEF;
    localparam logic [63:0] M_NOW   = 64'h4E6F772069732074;
    localparam logic [63:0] C_STD   = 64'h56CC09E7CFDC4CEF;
    localparam logic [63:0] C_ALT   = 64'h85E813540F0AB405;
    localparam logic [63:0] C_ZERO  = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] C_NOW   = 64'h3FA40E8A984D4815;

    encrypt dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .message (message),
        .key     (key),
        .cipher  (cipher)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %016h expected %016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts just after a completing edge (or reset release); the next edge is the load.
    task automatic run_block(input string tag, input logic [63:0] prev, input logic [63:0] exp);
        repeat (16) tick();
        chk({tag, "_hold"}, cipher, prev);
        tick();
        chk(tag, cipher, exp);
    endtask

    initial begin
        rst_n   = 1'b0;
        key     = K_STD;
        message = M_STD;
        #2;
        chk("reset_async", cipher, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held", cipher, 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("first_zero_e%0d", i), cipher, 64'h0);
        end
        tick();
        chk("std_edge17", cipher, C_STD);

        key = K_ALT;
        run_block("alt", C_STD, C_ALT);
        run_block("alt_repeat", C_ALT, C_ALT);

        key     = 64'h0;
        message = 64'h0;
        run_block("zero", C_ALT, C_ZERO);

        key     = K_PAR;
        message = M_STD;
        run_block("parity", C_ZERO, C_STD);

        // Message changes after the 5th edge of a block; only the next block sees it.
        key = K_STD;
        repeat (5) tick();
        message = M_NOW;
        repeat (11) tick();
        chk("midchg_hold", cipher, C_STD);
        tick();
        chk("midchg_old", cipher, C_STD);
        run_block("midchg_new", C_STD, C_NOW);

        // Abort a block at round 8 with an asynchronous reset.
        key     = K_ALT;
        message = M_STD;
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_async", cipher, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block("midrst_recover", 64'h0, C_ALT);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
